// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_sequencer
// Purpose  : Drives a 64-bit Am2901/Am2902/Am2904 datapath through a
//            shift-add multiply. The multiplicand is in R[ra_mcand] and the
//            multiplier comes from D. The product high word ends in
//            R[rb_acc] and the low word ends in Q.
// Ports    : clk, reset (sync, active-high)
//            start, abort, op_mode32, ra_mcand[3:0], rb_acc[3:0], q0 -- inputs
//            busy, done, step_cnt[6:0]                            -- status
//            Ialu[8:0], A[3:0], B[3:0], C0, mode32, Iss[12:0],
//            nCEM, nCEN                                           -- datapath
// Config   : `define MULSEQ_SIGNED_EN selects a two's-complement multiply.
//            When q0=1 on the last step, that step subtracts the multiplicand
//            (SUBR) instead of adding it.
// Revision : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
  parameter logic [12:0] ISS_STEP = 13'h0000,
  parameter logic [12:0] ISS_IDLE = 13'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        op_mode32,
  input  logic [3:0]  ra_mcand,
  input  logic [3:0]  rb_acc,
  input  logic        q0,
  output logic        busy,
  output logic        done,
  output logic [6:0]  step_cnt,
  output logic [8:0]  Ialu,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic        C0,
  output logic        mode32,
  output logic [12:0] Iss,
  output logic        nCEM,
  output logic        nCEN
);

  // Am2901 instruction words {dest, func, src}
  localparam logic [8:0] C_I_NOP    = 9'o140;
  localparam logic [8:0] C_I_LOADQ  = 9'o037;
  localparam logic [8:0] C_I_CLEAR  = 9'o361;
  localparam logic [8:0] C_I_ADD    = 9'o401;
  localparam logic [8:0] C_I_PASS   = 9'o403;
  localparam logic [8:0] C_I_FINISH = 9'o133;
`ifdef MULSEQ_SIGNED_EN
  localparam logic [8:0] C_I_SUBR   = 9'o411;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADQ  = 3'd1,
    S_CLEAR  = 3'd2,
    S_STEP   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_mode32;
  logic [3:0] r_ra;
  logic [3:0] r_rb;
  logic [6:0] r_step_cnt;
  logic       w_last_step;

  // The counter holds the number of completed steps. The step in progress is
  // therefore the last one when the counter equals N-1.
  assign w_last_step = (r_step_cnt == (r_mode32 ? 7'd31 : 7'd63));
  assign step_cnt    = r_step_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode32   <= 1'b0;
      r_ra       <= 4'd0;
      r_rb       <= 4'd0;
      r_step_cnt <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_mode32   <= op_mode32;
        r_ra       <= ra_mcand;
        r_rb       <= rb_acc;
        r_step_cnt <= 7'd0;
      end
      // An aborted step does not count as completed.
      if (r_state == S_STEP && !abort) begin
        r_step_cnt <= r_step_cnt + 7'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    Ialu        = C_I_NOP;
    A           = 4'd0;
    B           = 4'd0;
    C0          = 1'b0;
    mode32      = 1'b0;
    Iss         = ISS_IDLE;
    nCEM        = 1'b1;
    nCEN        = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOADQ;
        end
      end
      S_LOADQ: begin
        busy        = 1'b1;
        mode32      = r_mode32;
        Ialu        = C_I_LOADQ;
        A           = r_ra;
        B           = r_rb;
        w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        // The XOR of the accumulator with itself zeroes it.
        busy        = 1'b1;
        mode32      = r_mode32;
        Ialu        = C_I_CLEAR;
        A           = r_rb;
        B           = r_rb;
        w_state_nxt = S_STEP;
      end
      S_STEP: begin
        busy   = 1'b1;
        mode32 = r_mode32;
        Ialu   = q0 ? C_I_ADD : C_I_PASS;
        A      = r_ra;
        B      = r_rb;
        Iss    = ISS_STEP;
`ifdef MULSEQ_SIGNED_EN
        // In two's complement, the multiplier MSB has negative weight.
        if (w_last_step && q0) begin
          Ialu = C_I_SUBR;
          C0   = 1'b1;
        end
`endif
        if (w_last_step) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        // Pass the high word through Y so that the status flags reflect it.
        busy        = 1'b1;
        done        = 1'b1;
        mode32      = r_mode32;
        Ialu        = C_I_FINISH;
        A           = r_ra;
        B           = r_rb;
        nCEN        = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (r_state != S_IDLE && abort) begin
      w_state_nxt = S_IDLE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_sequencer
// Purpose  : Self-checking bench for mul_sequencer. A cycle-indexed reference
//            model predicts every output on every cycle. Directed runs pin the
//            done latency, and randomized traffic follows the directed runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

  localparam logic [12:0] C_ISS_STEP = 13'h00A5;
  localparam logic [12:0] C_ISS_IDLE = 13'h1F0;

  logic        clk = 1'b0;
  logic        reset, start, abort, op_mode32, q0;
  logic [3:0]  ra_mcand, rb_acc;
  logic        busy, done, C0, mode32, nCEM, nCEN;
  logic [6:0]  step_cnt;
  logic [8:0]  Ialu;
  logic [3:0]  A, B;
  logic [12:0] Iss;

  mul_sequencer #(.ISS_STEP(C_ISS_STEP), .ISS_IDLE(C_ISS_IDLE)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .op_mode32(op_mode32), .ra_mcand(ra_mcand), .rb_acc(rb_acc), .q0(q0),
    .busy(busy), .done(done), .step_cnt(step_cnt), .Ialu(Ialu), .A(A), .B(B),
    .C0(C0), .mode32(mode32), .Iss(Iss), .nCEM(nCEM), .nCEN(nCEN)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model. m_idx is the cycle number within the sequence:
  // 1 = LOADQ, 2 = CLEAR, 3..N+2 = steps 1..N, N+3 = FINISH.
  bit         m_busy = 1'b0;
  int         m_idx  = 0;
  int         m_cnt  = 0;
  bit         m_mode = 1'b0;
  logic [3:0] m_ra   = 4'd0;
  logic [3:0] m_rb   = 4'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        int         n;
        int         stp;
        bit         a_chk;
        logic       e_busy, e_done, e_c0, e_mode, e_ncen;
        logic [8:0] e_ialu;
        logic [3:0] e_a, e_b;
        logic [12:0] e_iss;
        n      = m_mode ? 32 : 64;
        e_busy = 1'b0; e_done = 1'b0; e_c0 = 1'b0; e_mode = 1'b0; e_ncen = 1'b1;
        e_ialu = 9'o140; e_a = 4'd0; e_b = 4'd0; e_iss = C_ISS_IDLE; a_chk = 1'b1;
        if (m_busy) begin
          e_busy = 1'b1;
          e_mode = m_mode;
          if (m_idx == 1) begin
            e_ialu = 9'o037; e_a = m_ra; e_b = m_rb;
          end else if (m_idx == 2) begin
            e_ialu = 9'o361; e_a = m_rb; e_b = m_rb;
          end else if (m_idx <= n + 2) begin
            stp    = m_idx - 2;
            e_ialu = q0 ? 9'o401 : 9'o403;
            e_a    = m_ra; e_b = m_rb; e_iss = C_ISS_STEP;
`ifdef MULSEQ_SIGNED_EN
            if (stp == n && q0) begin
              e_ialu = 9'o411; e_c0 = 1'b1;
            end
`endif
          end else begin
            e_ialu = 9'o133; e_done = 1'b1; e_ncen = 1'b0; e_b = m_rb; a_chk = 1'b0;
          end
        end
        chk("busy",     32'(busy),     32'(e_busy));
        chk("done",     32'(done),     32'(e_done));
        chk("step_cnt", 32'(step_cnt), 32'(m_cnt));
        chk("Ialu",     32'(Ialu),     32'(e_ialu));
        if (a_chk) chk("A", 32'(A), 32'(e_a));
        chk("B",        32'(B),        32'(e_b));
        chk("C0",       32'(C0),       32'(e_c0));
        chk("mode32",   32'(mode32),   32'(e_mode));
        chk("Iss",      32'(Iss),      32'(e_iss));
        chk("nCEM",     32'(nCEM),     32'(1'b1));
        chk("nCEN",     32'(nCEN),     32'(e_ncen));
      end
      @(posedge clk);
      // Advance the model with the inputs that the DUT sampled at this edge.
      if (reset) begin
        m_busy = 1'b0; m_idx = 0; m_cnt = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1; m_idx = 1; m_cnt = 0;
          m_mode = op_mode32; m_ra = ra_mcand; m_rb = rb_acc;
        end
      end else if (abort) begin
        m_busy = 1'b0; m_idx = 0;
      end else if (m_idx == (m_mode ? 32 : 64) + 3) begin
        m_busy = 1'b0; m_idx = 0;
      end else begin
        if (m_idx >= 3) m_cnt++;
        m_idx++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start one multiply and drive q0 for each cycle. pat selects the q0
  // stimulus: 0 = random, 1 = 1,0,1,0.. across the steps, 2 = always 1.
  // The multiply is aborted at cycle abort_at, and a stray start is driven
  // at cycle poke_at.
  task automatic run_op(input bit mode, input logic [3:0] ra, input logic [3:0] rb,
                        input int pat, input int abort_at, input int poke_at,
                        output int done_at, output int busy_cnt);
    int n;
    n = mode ? 32 : 64;
    start = 1'b1; op_mode32 = mode; ra_mcand = ra; rb_acc = rb;
    cyc();
    start = 1'b0;
    op_mode32 = 1'($urandom % 2); ra_mcand = 4'($urandom); rb_acc = 4'($urandom);
    done_at = 0; busy_cnt = 0;
    for (int j = 1; j <= n + 3; j++) begin
      q0    = (pat == 0) ? 1'($urandom % 2) : (pat == 1) ? 1'(j % 2) : 1'b1;
      abort = (j == abort_at);
      start = (j == poke_at);
      @(negedge clk);
      if (done === 1'b1) done_at = j;
      if (busy === 1'b1) busy_cnt++;
      cyc();
      abort = 1'b0; start = 1'b0;
      if (j == abort_at) break;
    end
  endtask

  initial begin
    int d, b;
    reset = 1'b1; start = 1'b0; abort = 1'b0; op_mode32 = 1'b0; q0 = 1'b0;
    ra_mcand = 4'd0; rb_acc = 4'd0;
    @(posedge clk);
    #1 checking = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (5) cyc();
    @(negedge clk);
    chk("idle_Ialu_literal", 32'(Ialu), 32'(9'o140));
    chk("idle_busy_literal", 32'(busy), 32'(1'b0));
    cyc();

    run_op(1'b0, 4'd2, 4'd5, 0, 0, 0, d, b);
    chk("done_cycle_64", 32'(d), 32'd67);
    chk("busy_cycles_64", 32'(b), 32'd67);

    run_op(1'b1, 4'd7, 4'd3, 1, 0, 0, d, b);
    chk("done_cycle_32", 32'(d), 32'd35);
    chk("busy_cycles_32", 32'(b), 32'd35);
    @(negedge clk);
    chk("step_cnt_hold_32", 32'(step_cnt), 32'd32);
    cyc();

    // Abort in step 10 (cycle 12), then restart in the next cycle.
    run_op(1'b0, 4'd1, 4'd9, 0, 12, 0, d, b);
    chk("abort_no_done", 32'(d), 32'd0);
    @(negedge clk);
    chk("abort_idle_Ialu", 32'(Ialu), 32'(9'o140));
    cyc();
    run_op(1'b1, 4'd4, 4'd4, 0, 0, 0, d, b);
    chk("restart_done", 32'(d), 32'd35);

    // A stray start during a step has no effect.
    run_op(1'b1, 4'd6, 4'd8, 2, 0, 15, d, b);
    chk("poke_done", 32'(d), 32'd35);
    repeat (3) cyc();

    // Abort in FINISH still shows done for that cycle.
    run_op(1'b1, 4'd11, 4'd12, 2, 35, 0, d, b);
    chk("abort_finish_done", 32'(d), 32'd35);

    // Reset in the middle of a sequence.
    start = 1'b1; op_mode32 = 1'b1; cyc(); start = 1'b0;
    repeat (6) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_busy", 32'(busy), 32'(1'b0));
    cyc();

    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom % 300) == 0;
      start     = ($urandom % 6) == 0;
      abort     = ($urandom % 60) == 0;
      op_mode32 = ($urandom % 4) != 0;
      ra_mcand  = 4'($urandom);
      rb_acc    = 4'($urandom);
      q0        = 1'($urandom % 2);
      cyc();
    end
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) cyc();
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
